// File: rtl/jedro_1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jedro_1_mem_arbiter
// Purpose  : Shares one single-port synchronous RAM (1-cycle read latency)
//            between the jedro_1 instruction-fetch port (read-only) and the
//            data port (read/write). The data port normally wins; a
//            starvation counter forces a fetch grant after MAX_STARVE
//            consecutive denied fetch cycles. Fully pipelined: one grant per
//            cycle, responses return exactly one cycle after the grant.
// Ports    :
//   clk_i, rstn_i                 clock, asynchronous active-low reset
//   i_req_i/i_addr_i              fetch request and address
//   i_gnt_o                       fetch accepted this cycle
//   i_rvalid_o/i_rdata_o          fetch response
//   d_req_i/d_we_i/d_be_i         data request, write flag, byte enables
//   d_addr_i/d_wdata_i            data address and write data
//   d_gnt_o                       data accepted this cycle
//   d_rvalid_o/d_rdata_o          data response / write ack
//   mem_en_o/mem_we_o             RAM enable and byte write enables
//   mem_addr_o/mem_wdata_o        RAM address and write data
//   mem_rdata_i                   RAM read data (1 cycle after enable)
// Revision : 1.0 - initial release
// ============================================================================
module jedro_1_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_STARVE = 3
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  // instruction-fetch port
  input  logic                    i_req_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic                    i_gnt_o,
  output logic                    i_rvalid_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  // data port
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  // memory port
  output logic                    mem_en_o,
  output logic [DATA_WIDTH/8-1:0] mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  // Counter must be able to hold MAX_STARVE; keep at least one bit so the
  // MAX_STARVE=0 configuration still has a legal (constant-zero) register.
  localparam int STARVE_W = (MAX_STARVE < 1) ? 1 : $clog2(MAX_STARVE + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  // Owner of the response that returns in the cycle after a grant.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  owner_e                owner_q, owner_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  fetch_gnt;
  logic                  data_gnt;

  // --------------------------------------------------------------------------
  // Grant decision (combinational, same cycle as the request)
  // --------------------------------------------------------------------------
  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    // Fetch wins when alone, or when it has been starved long enough.
    // With MAX_STARVE=0 the counter is permanently zero, so fetch always wins.
    if (i_req_i && (!d_req_i || (starve_q == STARVE_MAX))) begin
      fetch_gnt = 1'b1;
    end else if (d_req_i) begin
      data_gnt = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state: starvation counter and response owner
  // --------------------------------------------------------------------------
  always_comb begin
    starve_d = '0;
    owner_d  = OWN_NONE;

    // Only a denied, still-requesting fetch ages; anything else clears it.
    if (i_req_i && data_gnt) begin
      if (starve_q == STARVE_MAX) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end

    if (fetch_gnt) begin
      owner_d = OWN_FETCH;
    end else if (data_gnt) begin
      owner_d = OWN_DATA;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_q <= '0;
      owner_q  <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  // --------------------------------------------------------------------------
  // Memory drive: the winner's request goes straight to the RAM
  // --------------------------------------------------------------------------
  always_comb begin
    mem_en_o    = fetch_gnt | data_gnt;
    mem_addr_o  = fetch_gnt ? i_addr_i : d_addr_i;
    mem_we_o    = (data_gnt && d_we_i) ? d_be_i : {BE_WIDTH{1'b0}};
    mem_wdata_o = d_wdata_i;
  end

  // --------------------------------------------------------------------------
  // Grants and responses
  // --------------------------------------------------------------------------
  assign i_gnt_o    = fetch_gnt;
  assign d_gnt_o    = data_gnt;

  assign i_rvalid_o = (owner_q == OWN_FETCH);
  assign d_rvalid_o = (owner_q == OWN_DATA);

  // Read data is gated so an idle port never sees the other port's data.
  assign i_rdata_o  = i_rvalid_o ? mem_rdata_i : {DATA_WIDTH{1'b0}};
  assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : {DATA_WIDTH{1'b0}};

endmodule
`default_nettype wire

// File: tb/tb_jedro_1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jedro_1_mem_arbiter
// Purpose  : Scoreboard bench for jedro_1_mem_arbiter. A request driver
//            pushes expected responses at grant time; an independent monitor
//            pops and compares on every rvalid. A second instance with
//            MAX_STARVE=0 covers the fetch-always-wins configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jedro_1_mem_arbiter;

  logic        clk;
  logic        rst_n;
  int          cyc;
  int          n_chk;
  int          n_fail;

  // main DUT (MAX_STARVE = 3)
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // second DUT (MAX_STARVE = 0)
  logic        z_i_req, z_i_gnt, z_i_rvalid;
  logic [31:0] z_i_rdata;
  logic        z_d_req, z_d_gnt, z_d_rvalid;
  logic [31:0] z_d_rdata;
  logic        z_mem_en;
  logic [3:0]  z_mem_we;
  logic [31:0] z_mem_addr, z_mem_wdata;
  logic [31:0] z_mem_rdata;

  jedro_1_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_STARVE(3)) u_dut (
    .clk_i(clk), .rstn_i(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
    .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
    .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  jedro_1_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_STARVE(0)) u_dut0 (
    .clk_i(clk), .rstn_i(rst_n),
    .i_req_i(z_i_req), .i_addr_i(32'h0000_0010), .i_gnt_o(z_i_gnt),
    .i_rvalid_o(z_i_rvalid), .i_rdata_o(z_i_rdata),
    .d_req_i(z_d_req), .d_we_i(1'b0), .d_be_i(4'h0), .d_addr_i(32'h0000_0020),
    .d_wdata_i(32'h0), .d_gnt_o(z_d_gnt), .d_rvalid_o(z_d_rvalid),
    .d_rdata_o(z_d_rdata),
    .mem_en_o(z_mem_en), .mem_we_o(z_mem_we), .mem_addr_o(z_mem_addr),
    .mem_wdata_o(z_mem_wdata), .mem_rdata_i(z_mem_rdata)
  );

  assign z_mem_rdata = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // RAM model: 256 words, byte writes, 1-cycle registered read
  // --------------------------------------------------------------------------
  logic [31:0] ram [0:255];

  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  // --------------------------------------------------------------------------
  // Comparison helper
  // --------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Operation queues and scoreboards
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } fop_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } dop_t;

  typedef struct {
    logic        check_data;
    logic [31:0] exp;
    int          t0;
  } sb_t;

  fop_t fq[$];
  dop_t dq[$];
  sb_t  sb_i[$];
  sb_t  sb_d[$];

  logic [31:0] pat_bits;
  int          pat_n;

  task automatic add_f(input logic [31:0] addr, input logic [31:0] exp);
    fop_t op;
    op.addr = addr;
    op.exp  = exp;
    fq.push_back(op);
  endtask

  task automatic add_d(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
    dop_t op;
    op.we = we; op.be = be; op.addr = addr; op.wdata = wdata; op.exp = exp;
    dq.push_back(op);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present queue heads each cycle; on grant, retire the op and push its
  // expected response into the scoreboard.
  task automatic run_ops();
    int   guard;
    int   f_t0;
    sb_t  e;
    guard = 0;
    f_t0  = -1;
    while ((fq.size() > 0 || dq.size() > 0) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
      i_req = (fq.size() > 0);
      if (i_req) begin
        i_addr = fq[0].addr;
        if (f_t0 < 0) f_t0 = cyc;
      end
      d_req = (dq.size() > 0);
      if (d_req) begin
        d_we    = dq[0].we;
        d_be    = dq[0].be;
        d_addr  = dq[0].addr;
        d_wdata = dq[0].wdata;
      end
      @(negedge clk);
      chk("gnt_exclusive", {31'b0, i_gnt & d_gnt}, 32'h0);
      chk("i_gnt_without_req", {31'b0, i_gnt & ~i_req}, 32'h0);
      chk("d_gnt_without_req", {31'b0, d_gnt & ~d_req}, 32'h0);
      if (i_req ^ d_req)
        chk("lone_req_wins", {31'b0, i_req ? i_gnt : d_gnt}, 32'h1);
      chk("mem_en", {31'b0, mem_en}, {31'b0, i_gnt | d_gnt});
      if (i_gnt) chk("mem_addr_fetch", mem_addr, i_addr);
      else if (d_gnt) chk("mem_addr_data", mem_addr, d_addr);
      chk("mem_we", {28'b0, mem_we}, {28'b0, (d_gnt && d_we) ? d_be : 4'h0});
      if (d_gnt && d_we) chk("mem_wdata", mem_wdata, d_wdata);
      if (i_gnt && fq.size() > 0) begin
        e.check_data = 1'b1;
        e.exp        = fq[0].exp;
        e.t0         = f_t0;
        sb_i.push_back(e);
        f_t0 = -1;
        void'(fq.pop_front());
        pat_bits = {pat_bits[30:0], 1'b1};
        pat_n++;
      end
      if (d_gnt && dq.size() > 0) begin
        e.check_data = ~dq[0].we;
        e.exp        = dq[0].exp;
        e.t0         = cyc;
        sb_d.push_back(e);
        void'(dq.pop_front());
        pat_bits = {pat_bits[30:0], 1'b0};
        pat_n++;
      end
    end
    if (guard >= 200) begin
      chk("run_ops_timeout", 32'h1, 32'h0);
      fq.delete();
      dq.delete();
    end
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Response monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    sb_t m;
    if (rst_n) begin
      if (i_rvalid) begin
        if (sb_i.size() == 0) begin
          chk("i_rvalid_unexpected", 32'h1, 32'h0);
        end else begin
          m = sb_i.pop_front();
          chk("i_rdata", i_rdata, m.exp);
          chk("i_latency_le4", {31'b0, (cyc - m.t0) > 4}, 32'h0);
        end
      end else begin
        chk("i_rdata_idle", i_rdata, 32'h0);
      end
      if (d_rvalid) begin
        if (sb_d.size() == 0) begin
          chk("d_rvalid_unexpected", 32'h1, 32'h0);
        end else begin
          m = sb_d.pop_front();
          if (m.check_data) chk("d_rdata", d_rdata, m.exp);
        end
      end else begin
        chk("d_rdata_idle", d_rdata, 32'h0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Watchdog
  // --------------------------------------------------------------------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_i_gnt"},    {31'b0, i_gnt},    32'h0);
    chk({tag, "_d_gnt"},    {31'b0, d_gnt},    32'h0);
    chk({tag, "_i_rvalid"}, {31'b0, i_rvalid}, 32'h0);
    chk({tag, "_d_rvalid"}, {31'b0, d_rvalid}, 32'h0);
    chk({tag, "_i_rdata"},  i_rdata,           32'h0);
    chk({tag, "_d_rdata"},  d_rdata,           32'h0);
    chk({tag, "_mem_en"},   {31'b0, mem_en},   32'h0);
    chk({tag, "_mem_we"},   {28'b0, mem_we},   32'h0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    n_chk    = 0;
    n_fail   = 0;
    cyc      = 0;
    pat_bits = '0;
    pat_n    = 0;
    rst_n    = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    z_i_req = 1'b0; z_d_req = 1'b0;
    for (int k = 0; k < 256; k++) ram[k] = k;
    ram[128] = 32'h1122_3344;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Fetch-only stream: words 0,1,2
    add_f(32'h0, 32'h0);
    add_f(32'h4, 32'h1);
    add_f(32'h8, 32'h2);
    run_ops();
    idle(3);

    // Full-word write then read back
    add_d(1'b1, 4'hF, 32'h100, 32'h0000_000E, 32'h0);
    add_d(1'b0, 4'h0, 32'h100, 32'h0,         32'h0000_000E);
    run_ops();
    idle(3);

    // Byte-lane 1 write into 0x11223344
    add_d(1'b1, 4'h2, 32'h200, 32'h0000_AB00, 32'h0);
    add_d(1'b0, 4'h0, 32'h200, 32'h0,         32'h1122_AB44);
    run_ops();
    idle(3);

    // Both requesting: expect D,D,D,I repeating
    pat_bits = '0;
    pat_n    = 0;
    for (int j = 0; j < 9; j++)
      add_d(1'b0, 4'h0, 32'h40 + 32'(4*j), 32'h0, 32'd16 + 32'(j));
    for (int j = 0; j < 3; j++)
      add_f(32'h80 + 32'(4*j), 32'd32 + 32'(j));
    run_ops();
    chk("grant_pattern", pat_bits, 32'h0000_0111);
    chk("grant_count", 32'(pat_n), 32'd12);
    idle(3);

    // MAX_STARVE = 0: fetch always wins
    z_i_req = 1'b1;
    z_d_req = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("z_i_gnt", {31'b0, z_i_gnt}, 32'h1);
      chk("z_d_gnt", {31'b0, z_d_gnt}, 32'h0);
    end
    @(posedge clk);
    #1;
    z_i_req = 1'b0;
    z_d_req = 1'b0;
    idle(2);

    // Reset pulse right after a read grant: response must be dropped
    add_d(1'b0, 4'h0, 32'h100, 32'h0, 32'h0000_000E);
    run_ops();
    rst_n = 1'b0;
    sb_d.delete();
    #1;
    check_outputs_zero("rst_pulse");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    add_f(32'h8, 32'h2);
    run_ops();
    idle(3);

    chk("sb_i_drained", 32'(sb_i.size()), 32'h0);
    chk("sb_d_drained", 32'(sb_d.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
